// File: rtl/clock_12hr_core_if.sv
// Control/load inputs and registered time-of-day outputs of clock_12hr_core.
// master = the block driving en/load, slave = the time core.
interface clock_12hr_core_if;
    logic       en;
    logic       load;
    logic [3:0] ld_hr;
    logic [5:0] ld_min;
    logic       ld_pm;
    logic [5:0] sec;
    logic [5:0] min;
    logic [3:0] hr;
    logic       pm;
    logic       sec_tick;
    logic       ld_err;

    modport master (
        output en, load, ld_hr, ld_min, ld_pm,
        input  sec, min, hr, pm, sec_tick, ld_err
    );

    modport slave (
        input  en, load, ld_hr, ld_min, ld_pm,
        output sec, min, hr, pm, sec_tick, ld_err
    );
endinterface

// File: rtl/clock_12hr_core.sv
// 12-hour hh:mm:ss clock with AM/PM: one-second prescaler, mod-60 sec/min
// cascade and 1..12 hour wrap, all updated in a single edge.
module clock_12hr_core #(
    parameter int TICK_DIV = 100
) (
    input  logic              clk,
    input  logic              rst,
    clock_12hr_core_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] psc;
    logic          ld_ok;
    logic          wrap;
    logic [5:0]    sec_n;
    logic [5:0]    min_n;
    logic [3:0]    hr_n;
    logic          pm_n;

    always_comb begin
        ld_ok = (bus.ld_hr >= 4'd1) && (bus.ld_hr <= 4'd12) && (bus.ld_min <= 6'd59);
        wrap  = (psc == PW'(TICK_DIV - 1));
        sec_n = bus.sec + 6'd1;
        min_n = bus.min;
        hr_n  = bus.hr;
        pm_n  = bus.pm;
        // full 11:59:59 PM -> 12:00:00 AM cascade resolves combinationally
        if (bus.sec == 6'd59) begin
            sec_n = 6'd0;
            min_n = bus.min + 6'd1;
            if (bus.min == 6'd59) begin
                min_n = 6'd0;
                hr_n  = (bus.hr == 4'd12) ? 4'd1 : bus.hr + 4'd1;
                if (bus.hr == 4'd11) pm_n = ~bus.pm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc          <= '0;
            bus.sec      <= 6'd0;
            bus.min      <= 6'd0;
            bus.hr       <= 4'd12;
            bus.pm       <= 1'b0;
            bus.sec_tick <= 1'b0;
            bus.ld_err   <= 1'b0;
        end else begin
            bus.sec_tick <= 1'b0;
            bus.ld_err   <= 1'b0;
            if (bus.load && ld_ok) begin
                // load wins over a coincident tick, which is dropped
                psc     <= '0;
                bus.sec <= 6'd0;
                bus.min <= bus.ld_min;
                bus.hr  <= bus.ld_hr;
                bus.pm  <= bus.ld_pm;
            end else begin
                // rejected load leaves the prescaler phase running
                if (bus.load) bus.ld_err <= 1'b1;
                if (bus.en) begin
                    if (wrap) begin
                        psc          <= '0;
                        bus.sec      <= sec_n;
                        bus.min      <= min_n;
                        bus.hr       <= hr_n;
                        bus.pm       <= pm_n;
                        bus.sec_tick <= 1'b1;
                    end else begin
                        psc <= psc + PW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_12hr_core.sv
// Bench for clock_12hr_core: seconds-of-day reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_clock_12hr_core;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    clock_12hr_core_if bus ();

    clock_12hr_core #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference: time kept as seconds since midnight, phase as cycle count
    int m_t    = 0;
    int m_ph   = 0;
    bit m_tick = 0;
    bit m_err  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t = 0; m_ph = 0; m_tick = 0; m_err = 0;
        end else begin
            bit ok;
            ok = bus.load && bus.ld_hr >= 1 && bus.ld_hr <= 12 && bus.ld_min < 60;
            m_tick = 0;
            m_err  = bus.load && !ok;
            if (ok) begin
                m_t  = ((int'(bus.ld_hr) % 12) + (bus.ld_pm ? 12 : 0)) * 3600 + int'(bus.ld_min) * 60;
                m_ph = 0;
            end else if (bus.en) begin
                m_ph = m_ph + 1;
                if (m_ph == TD) begin
                    m_ph = 0;
                    m_t = (m_t + 1) % 86400;
                    m_tick = 1;
                end
            end
        end
    end

    function automatic logic [18:0] model_out();
        int h24, h12;
        h24 = m_t / 3600;
        h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
        return {6'(m_t % 60), 6'((m_t / 60) % 60), 4'(h12), h24 >= 12, m_tick, m_err};
    endfunction

    always @(negedge clk) begin
        logic [18:0] act, exp;
        act = {bus.sec, bus.min, bus.hr, bus.pm, bus.sec_tick, bus.ld_err};
        exp = model_out();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle_model t=%0t act sec=%0d min=%0d hr=%0d pm=%0d tick=%0d err=%0d exp sec=%0d min=%0d hr=%0d pm=%0d tick=%0d err=%0d",
                     $time, act[18:13], act[12:7], act[6:3], act[2], act[1], act[0],
                     exp[18:13], exp[12:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s, input int p);
        check({name, ".hr"}, int'(bus.hr), h);
        check({name, ".min"}, int'(bus.min), m);
        check({name, ".sec"}, int'(bus.sec), s);
        check({name, ".pm"}, int'(bus.pm), p);
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int h, input int m, input bit p);
        bus.load = 1'b1; bus.ld_hr = 4'(h); bus.ld_min = 6'(m); bus.ld_pm = p;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        int n;
        bus.en = 1'b0; bus.load = 1'b0; bus.ld_hr = 4'd0; bus.ld_min = 6'd0; bus.ld_pm = 1'b0;
        #12;
        check_time("reset", 12, 0, 0, 0);
        check("reset.tick", int'(bus.sec_tick), 0);
        check("reset.err", int'(bus.ld_err), 0);

        @(negedge clk);
        rst = 1'b1; bus.en = 1'b1;
        edges(3);
        check("first.pre_tick", int'(bus.sec_tick), 0);
        edges(1);
        check("first.sec", int'(bus.sec), 1);
        check("first.tick", int'(bus.sec_tick), 1);
        edges(4);
        check("second.sec", int'(bus.sec), 2);
        edges(2);
        bus.en = 1'b0;
        edges(10);
        check("hold.sec", int'(bus.sec), 2);
        check("hold.tick", int'(bus.sec_tick), 0);
        bus.en = 1'b1;
        edges(1);
        check("resume.early", int'(bus.sec), 2);
        edges(1);
        check("resume.sec", int'(bus.sec), 3);
        check("resume.tick", int'(bus.sec_tick), 1);

        do_load(11, 59, 0);
        check_time("load1159am", 11, 59, 0, 0);
        check("load.tick", int'(bus.sec_tick), 0);
        edges(60 * TD);
        check_time("am_to_pm", 12, 0, 0, 1);

        do_load(11, 59, 1);
        edges(60 * TD);
        check_time("pm_to_am", 12, 0, 0, 0);

        do_load(12, 59, 1);
        n = 0;
        repeat (60 * TD) begin
            @(negedge clk);
            if (bus.sec_tick) n++;
        end
        check_time("twelve_to_one", 1, 0, 0, 1);
        check("twelve_to_one.ticks", n, 60);

        // prescaler now at 0; bring it to TICK_DIV-1, then collide a load
        edges(TD - 1);
        do_load(5, 30, 0);
        check_time("collide", 5, 30, 0, 0);
        check("collide.tick", int'(bus.sec_tick), 0);
        edges(TD - 1);
        check("collide.pre", int'(bus.sec_tick), 0);
        edges(1);
        check("collide.next_tick", int'(bus.sec_tick), 1);
        check("collide.next_sec", int'(bus.sec), 1);

        do_load(4, 10, 0);
        edges(20 * TD);
        check_time("at_41020", 4, 10, 20, 0);
        for (int i = 0; i < 3; i++) begin
            int bh, bm, s0;
            bh = (i == 0) ? 13 : (i == 1) ? 0 : 4;
            bm = (i == 2) ? 60 : 10;
            s0 = 20 + i;
            do_load(bh, bm, 1);
            check_time($sformatf("bad%0d.keep", i), 4, 10, s0, 0);
            check($sformatf("bad%0d.err", i), int'(bus.ld_err), 1);
            edges(1);
            check($sformatf("bad%0d.err_off", i), int'(bus.ld_err), 0);
            edges(TD - 3);
            check($sformatf("bad%0d.pre", i), int'(bus.sec_tick), 0);
            edges(1);
            check($sformatf("bad%0d.tick", i), int'(bus.sec_tick), 1);
            check($sformatf("bad%0d.sec", i), int'(bus.sec), s0 + 1);
        end

        do_load(3, 7, 1);
        edges(42 * TD);
        check_time("at_30742pm", 3, 7, 42, 1);
        #2 rst = 1'b0;
        #1;
        check_time("midrst", 12, 0, 0, 0);
        check("midrst.err", int'(bus.ld_err), 0);
        check("midrst.tick", int'(bus.sec_tick), 0);
        @(negedge clk);
        rst = 1'b1;
        edges(TD - 1);
        check("postrst.pre", int'(bus.sec), 0);
        edges(1);
        check("postrst.sec", int'(bus.sec), 1);

        // random traffic, held loads included, checked by the cycle model
        repeat (3000) begin
            bus.en    = ($urandom_range(0, 9) != 0);
            bus.load  = ($urandom_range(0, 40) == 0) || (bus.load && $urandom_range(0, 1) == 1);
            bus.ld_hr = 4'($urandom_range(0, 15));
            bus.ld_min = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(55, 63)) : 6'($urandom_range(0, 63));
            bus.ld_pm = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.load = 1'b0;
        edges(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
